// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: datapath widths, ALU op encodings
// and the EX/MEM pipeline register layout. The control unit uses the same encodings.
package execute_stage_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0] aluOut;
    logic            zero;
    logic [XLEN-1:0] branchTarget;
    logic [XLEN-1:0] writeData;
    logic [REGW-1:0] writeReg;
    logic [XLEN-1:0] pc;
  } exMemT;

endpackage

// File: rtl/execute_stage_if.sv
// Bundle of execute-stage inputs (from ID/EX) and EX/MEM register outputs.
// master = upstream/downstream pipeline side, slave = the execute stage itself.
interface execute_stage_if;
  import execute_stage_pkg::*;

  logic            dhit;
  logic            sendNop;
  logic [XLEN-1:0] pcDE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] rd2E;
  logic [XLEN-1:0] SignImmE;
  logic            ALUSrcE;
  logic [2:0]      AluControlE;
  logic [XLEN-1:0] WriteDataE;
  logic [REGW-1:0] WriteRegE;

  logic [XLEN-1:0] ALUOutM;
  logic            ZeroM;
  logic [XLEN-1:0] BranchTargetM;
  logic [XLEN-1:0] WriteDataM;
  logic [REGW-1:0] WriteRegM;
  logic [XLEN-1:0] pcEM;

  modport master (
    output dhit, sendNop, pcDE, SrcAE, rd2E, SignImmE, ALUSrcE,
           AluControlE, WriteDataE, WriteRegE,
    input  ALUOutM, ZeroM, BranchTargetM, WriteDataM, WriteRegM, pcEM
  );

  modport slave (
    input  dhit, sendNop, pcDE, SrcAE, rd2E, SignImmE, ALUSrcE,
           AluControlE, WriteDataE, WriteRegE,
    output ALUOutM, ZeroM, BranchTargetM, WriteDataM, WriteRegM, pcEM
  );

endinterface

// File: rtl/execute_stage_alu.sv
// Combinational 32-bit ALU for the execute stage; wraps modulo 2^32 and
// ignores carry/overflow. Shifts use only the low five bits of b.
module exec_alu
  import execute_stage_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  always_comb begin
    result = '0;
    unique case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
      ALU_SUB: result = a - b;
      ALU_SLT: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand-B select, ALU, branch-target adder and the EX/MEM
// pipeline register with stall (dhit low) and bubble insertion (sendNop).
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  execute_stage_if.slave bus
);

  logic [XLEN-1:0] srcBE;
  logic [XLEN-1:0] aluResult;
  logic            aluZero;
  logic [XLEN-1:0] branchTarget;
  exMemT           exMemD;
  exMemT           exMemQ;

  assign srcBE        = bus.ALUSrcE ? bus.SignImmE : bus.rd2E;
  assign branchTarget = bus.pcDE + bus.SignImmE;

  exec_alu uAlu (
    .a      (bus.SrcAE),
    .b      (srcBE),
    .op     (bus.AluControlE),
    .result (aluResult),
    .zero   (aluZero)
  );

  always_comb begin
    exMemD              = '0;
    exMemD.aluOut       = aluResult;
    exMemD.zero         = aluZero;
    exMemD.branchTarget = branchTarget;
    exMemD.writeData    = bus.WriteDataE;
    exMemD.writeReg     = bus.WriteRegE;
    exMemD.pc           = bus.pcDE;
  end

  // Stall wins over flush: a held instruction must not be replaced by a bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      exMemQ <= '0;
    end else if (bus.dhit) begin
      if (bus.sendNop) exMemQ <= '0;
      else             exMemQ <= exMemD;
    end
  end

  assign bus.ALUOutM       = exMemQ.aluOut;
  assign bus.ZeroM         = exMemQ.zero;
  assign bus.BranchTargetM = exMemQ.branchTarget;
  assign bus.WriteDataM    = exMemQ.writeData;
  assign bus.WriteRegM     = exMemQ.writeReg;
  assign bus.pcEM          = exMemQ.pc;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage: reset, ALU ops, branch
// target wrap, stall, flush and reset release.
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic clk;
  logic reset;
  int   nAsserts;
  int   nFails;

  execute_stage_if bus ();

  execute_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [31:0] alu, input logic zero,
                          input logic [31:0] tgt, input logic [31:0] wd,
                          input logic [4:0] wr, input logic [31:0] pc);
    chk({tag, ".ALUOutM"}, bus.ALUOutM, alu);
    chk({tag, ".ZeroM"}, {31'd0, bus.ZeroM}, {31'd0, zero});
    chk({tag, ".BranchTargetM"}, bus.BranchTargetM, tgt);
    chk({tag, ".WriteDataM"}, bus.WriteDataM, wd);
    chk({tag, ".WriteRegM"}, {27'd0, bus.WriteRegM}, {27'd0, wr});
    chk({tag, ".pcEM"}, bus.pcEM, pc);
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] rd2,
                       input logic [31:0] imm, input logic aluSrc, input logic [2:0] op,
                       input logic [31:0] wd, input logic [4:0] wr);
    bus.pcDE        = pc;
    bus.SrcAE       = a;
    bus.rd2E        = rd2;
    bus.SignImmE    = imm;
    bus.ALUSrcE     = aluSrc;
    bus.AluControlE = op;
    bus.WriteDataE  = wd;
    bus.WriteRegE   = wr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nAsserts = 0;
    nFails   = 0;

    // Reset with random inputs
    reset       = 1'b0;
    bus.dhit    = 1'b1;
    bus.sendNop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive($urandom, $urandom, $urandom, $urandom, 1'($urandom), 3'($urandom),
            $urandom, 5'($urandom));
      bus.dhit = 1'($urandom);
      tick();
      checkAll("reset", 32'd0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0);
    end

    reset       = 1'b1;
    bus.dhit    = 1'b1;
    bus.sendNop = 1'b0;

    drive(32'h40, 32'd5, 32'd100, 32'd7, 1'b1, ALU_ADD, 32'hDEAD, 5'd3);
    tick();
    checkAll("addImm", 32'd12, 1'b0, 32'h47, 32'hDEAD, 5'd3, 32'h40);

    drive(32'h44, 32'd9, 32'd9, 32'h10, 1'b0, ALU_SUB, 32'h1111, 5'd4);
    tick();
    checkAll("subZero", 32'd0, 1'b1, 32'h54, 32'h1111, 5'd4, 32'h44);

    drive(32'h48, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, ALU_SLT, 32'h2222, 5'd6);
    tick();
    checkAll("sltNeg", 32'd1, 1'b0, 32'h48, 32'h2222, 5'd6, 32'h48);

    drive(32'h4C, 32'd1, 32'hFFFFFFFF, 32'h4, 1'b0, ALU_SLT, 32'h3333, 5'd7);
    tick();
    checkAll("sltPos", 32'd0, 1'b1, 32'h50, 32'h3333, 5'd7, 32'h4C);

    drive(32'h50, 32'hF0F01234, 32'h0FF0FFFF, 32'h0, 1'b0, ALU_AND, 32'h0, 5'd8);
    tick();
    chk("and", bus.ALUOutM, 32'h00F01234);

    drive(32'h54, 32'hF0F01234, 32'h0FF0FFFF, 32'h0, 1'b0, ALU_OR, 32'h0, 5'd8);
    tick();
    chk("or", bus.ALUOutM, 32'hFFF0FFFF);

    drive(32'h58, 32'hF0F01234, 32'h0FF0FFFF, 32'h0, 1'b0, ALU_XOR, 32'h0, 5'd8);
    tick();
    chk("xor", bus.ALUOutM, 32'hFF00EDCB);

    drive(32'h5C, 32'd1, 32'd0, 32'h24, 1'b1, ALU_SLL, 32'h0, 5'd9);
    tick();
    chk("sll", bus.ALUOutM, 32'h10);
    chk("sllTarget", bus.BranchTargetM, 32'h80);

    drive(32'h60, 32'h80000000, 32'd31, 32'h0, 1'b0, ALU_SRL, 32'h0, 5'd9);
    tick();
    chk("srl", bus.ALUOutM, 32'd1);

    drive(32'h64, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, ALU_ADD, 32'h0, 5'd10);
    tick();
    chk("addWrap", bus.ALUOutM, 32'd0);
    chk("addWrapZero", {31'd0, bus.ZeroM}, 32'd1);

    // Branch targets, including negative offset and 32-bit wrap
    drive(32'h100, 32'd8, 32'd0, 32'hFFFFFFF8, 1'b1, ALU_ADD, 32'h5555, 5'd11);
    tick();
    checkAll("brNeg", 32'd0, 1'b1, 32'hF8, 32'h5555, 5'd11, 32'h100);

    drive(32'hFFFFFFFC, 32'd1, 32'd0, 32'd8, 1'b1, ALU_ADD, 32'h6666, 5'd12);
    tick();
    checkAll("brWrap", 32'd9, 1'b0, 32'h4, 32'h6666, 5'd12, 32'hFFFFFFFC);

    // Stall holds even with sendNop asserted
    drive(32'h200, 32'd20, 32'd3, 32'h0, 1'b0, ALU_SUB, 32'hCAFE, 5'd13);
    tick();
    checkAll("preStall", 32'd17, 1'b0, 32'h200, 32'hCAFE, 5'd13, 32'h200);
    bus.dhit    = 1'b0;
    bus.sendNop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h300 + 32'(i), 32'd1 + 32'(i), 32'd1, 32'h8, 1'b1, ALU_OR, 32'hBEEF, 5'd20);
      tick();
      checkAll("stall", 32'd17, 1'b0, 32'h200, 32'hCAFE, 5'd13, 32'h200);
    end

    // Flush loads a bubble, next edge loads normally
    bus.dhit    = 1'b1;
    bus.sendNop = 1'b1;
    drive(32'h400, 32'd2, 32'd3, 32'h10, 1'b0, ALU_ADD, 32'h7777, 5'd5);
    tick();
    checkAll("flush", 32'd0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0);
    bus.sendNop = 1'b0;
    tick();
    checkAll("postFlush", 32'd5, 1'b0, 32'h410, 32'h7777, 5'd5, 32'h400);

    // Reset overrides stall, then first enabled edge loads
    reset    = 1'b0;
    bus.dhit = 1'b0;
    tick();
    checkAll("resetStall", 32'd0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0);
    reset    = 1'b1;
    bus.dhit = 1'b1;
    drive(32'h500, 32'd6, 32'd0, 32'd4, 1'b1, ALU_XOR, 32'h8888, 5'd31);
    tick();
    checkAll("postReset", 32'd2, 1'b0, 32'h504, 32'h8888, 5'd31, 32'h500);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
